// File: rtl/uart_frame_packer_pkg.sv
// Shared definitions for the UART frame packer.
// Contents:
//   BYTE_W       width of one received byte
//   DEF_*        default values for BYTES, DEPTH and TIMEOUT
//   state_e      output handshake FSM states (idle, load, wait)
package uart_frame_packer_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned DEF_BYTES   = 3;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_TIMEOUT = 1000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StWait = 2'd2
    } state_e;

endpackage

// File: rtl/uart_frame_packer_frame_fifo.sv
// frame_fifo: synchronous FIFO of complete frames.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   i_push       write i_data; accepted when not full, or when a pop happens in the same cycle
//   i_data       frame to write
//   i_pop        remove the head; ignored when empty
//   o_data       current head (combinational read of the storage)
//   o_full       DEPTH frames held
//   o_empty      no frames held
//   o_level      number of frames held
module frame_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push then.
    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_frame_packer.sv
// uart_frame_packer: packs BYTES received UART bytes into one frame, queues up to DEPTH frames
// and hands them one at a time to the encoder with a load pulse.
// Optional feature macro: FRAME_TIMEOUT_EN enables the inter-byte timeout that discards a
// partial frame after TIMEOUT idle cycles (drop pulses); without it drop is tied low.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   in_valid     one-cycle strobe per received byte
//   in_data      received byte
//   out_ready    encoder idle/done level
//   out_data     registered frame presented to the encoder
//   out_load     one-cycle load pulse
//   level        frames held in the FIFO
//   overflow     sticky: a complete frame was lost to a full FIFO
//   drop         one-cycle pulse: partial frame discarded by timeout
module uart_frame_packer
    import uart_frame_packer_pkg::*;
#(
    parameter int unsigned BYTES     = DEF_BYTES,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [BYTE_W-1:0]          in_data,
    input  logic                       out_ready,
    output logic [BYTE_W*BYTES-1:0]    out_data,
    output logic                       out_load,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       drop
);

    localparam int unsigned FRAME_W = BYTE_W * BYTES;
    localparam int unsigned IDX_W   = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0]   r_idx;
    logic [FRAME_W-1:0] r_frame;
    logic [FRAME_W-1:0] w_frame;
    logic               w_last;
    logic               w_push;
    logic               w_expire;

    state_e             r_state;
    state_e             w_state_next;
    logic               w_pop;
    logic               w_load;
    logic [FRAME_W-1:0] r_out_data;
    logic               r_overflow;
    logic [FRAME_W-1:0] w_fifo_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    // ---------------------------------------------------------------- accumulator
    // Frame with the incoming byte merged at the current index; pushed as-is on the last byte.
    always_comb begin
        w_frame = r_frame;
        for (int k = 0; k < BYTES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                if (MSB_FIRST) begin
                    w_frame[BYTE_W*(BYTES-1-k) +: BYTE_W] = in_data;
                end else begin
                    w_frame[BYTE_W*k +: BYTE_W] = in_data;
                end
            end
        end
    end

    assign w_last = (r_idx == IDX_W'(BYTES - 1));
    assign w_push = in_valid && w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            r_frame <= '0;
        end else if (in_valid) begin
            r_frame <= w_frame;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
        end else if (w_expire) begin
            r_idx <= '0;
        end
    end

    // ---------------------------------------------------------------- timeout
`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_drop;

    // Counter value TIMEOUT-1 marks the TIMEOUT-th idle cycle; a byte in that cycle wins.
    assign w_expire = !in_valid && (r_idx != '0) && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= w_expire;
            if (in_valid || w_expire || (r_idx == '0)) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    assign drop = r_drop;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_expire         = 1'b0;
    assign drop             = 1'b0;
`endif

    // ---------------------------------------------------------------- frame FIFO
    frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_frame),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (level)
    );

    // ---------------------------------------------------------------- output FSM
    // Idle also looks at a push in flight so a frame into an empty FIFO loads next cycle.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if ((!w_fifo_empty || w_push) && out_ready) w_state_next = StLoad;
            end
            StLoad: begin
                w_pop        = 1'b1;
                w_load       = 1'b1;
                w_state_next = StWait;
            end
            StWait: begin
                if (!out_ready) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_out_data <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) r_out_data <= w_fifo_head;
            if (w_push && w_fifo_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign out_data = r_out_data;
    assign out_load = w_load;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_frame_packer.sv
module tb_uart_frame_packer;

    localparam int unsigned TMO = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out_ready = 1'b1;
    logic [23:0] out_data;
    logic        out_load;
    logic [2:0]  level;
    logic        overflow;
    logic        drop;

    logic        in_valid2 = 1'b0;
    logic [7:0]  in_data2 = 8'h00;
    logic        out_ready2 = 1'b1;
    logic [15:0] out_data2;
    logic        out_load2;
    logic [2:0]  level2;
    logic        overflow2;
    logic        drop2;

    int          checks = 0;
    int          failures = 0;
    int          load_cnt = 0;
    logic [23:0] exp_q[$];

    uart_frame_packer #(
        .BYTES     (3),
        .DEPTH     (4),
        .MSB_FIRST (1'b1),
        .TIMEOUT   (TMO)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_load  (out_load),
        .level     (level),
        .overflow  (overflow),
        .drop      (drop)
    );

    uart_frame_packer #(
        .BYTES     (2),
        .DEPTH     (4),
        .MSB_FIRST (1'b0),
        .TIMEOUT   (TMO)
    ) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid2),
        .in_data   (in_data2),
        .out_ready (out_ready2),
        .out_data  (out_data2),
        .out_load  (out_load2),
        .level     (level2),
        .overflow  (overflow2),
        .drop      (drop2)
    );

    always #5 clk = ~clk;

    // Scoreboard: every load is followed one cycle later by out_data holding the queue head.
    initial begin
        bit          pending;
        logic [23:0] exp;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_load got=%h required=no load", out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data !== exp) begin
                        failures++;
                        $display("FAIL frame_data got=%h required=%h", out_data, exp);
                    end
                end
            end
            if (out_load === 1'b1) begin
                load_cnt++;
                pending = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Returns at the negedge of the cycle following the byte strobe.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_byte2(input logic [7:0] b);
        @(negedge clk);
        in_valid2 = 1'b1;
        in_data2  = b;
        @(negedge clk);
        in_valid2 = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] f, input bit accept);
        send_byte(f[23:16]);
        send_byte(f[15:8]);
        if (accept) exp_q.push_back(f);
        send_byte(f[7:0]);
    endtask

    // Encoder starts: drop ready until the FSM has seen it low, then go idle again.
    task automatic finish_ack();
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
    endtask

    task automatic serve_one(input string name);
        bit seen;
        seen = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_load === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_load got=none required=pulse", name);
        end
        finish_ack();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_data, out_load, level, overflow, drop} !== 29'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%b/%0d/%b/%b required=0/0/0/0/0",
                     out_data, out_load, level, overflow, drop);
        end
        checks++;
        if ({out_data2, out_load2, level2} !== 20'd0) begin
            failures++;
            $display("FAIL reset_outputs2 got=%h/%b/%0d required=0/0/0",
                     out_data2, out_load2, level2);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int loads0;
        loads0 = load_cnt;
        out_ready = 1'b1;
        send_frame(24'hA1B2C3, 1'b1);
        checks++;
        if (out_load !== 1'b1 || level !== 3'd1) begin
            failures++;
            $display("FAIL basic_timing got=load %b level %0d required=load 1 level 1",
                     out_load, level);
        end
        finish_ack();
        checks++;
        if (level !== 3'd0 || exp_q.size() != 0 || load_cnt != loads0 + 1) begin
            failures++;
            $display("FAIL basic_end got=level %0d pending %0d loads %0d required=0 0 %0d",
                     level, exp_q.size(), load_cnt - loads0, 1);
        end
    endtask

    task automatic test_queueing();
        int loads0;
        loads0 = load_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(24'h100000 * (i + 1) + 24'h0203 * i, 1'b1);
        @(negedge clk);
        checks++;
        if (level !== 3'd4 || load_cnt != loads0) begin
            failures++;
            $display("FAIL queue_fill got=level %0d loads %0d required=level 4 loads 0",
                     level, load_cnt - loads0);
        end
        for (int i = 0; i < 4; i++) serve_one("queue");
        checks++;
        if (level !== 3'd0 || exp_q.size() != 0 || load_cnt != loads0 + 4) begin
            failures++;
            $display("FAIL queue_drain got=level %0d pending %0d loads %0d required=0 0 4",
                     level, exp_q.size(), load_cnt - loads0);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        send_frame(24'h0A0001, 1'b1);
        send_frame(24'h0B0002, 1'b1);
        send_frame(24'h0C0003, 1'b1);
        send_frame(24'h0D0004, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_early got=%b required=0", overflow);
        end
        send_frame(24'hEEEEEE, 1'b0);
        checks++;
        if (overflow !== 1'b1 || level !== 3'd4) begin
            failures++;
            $display("FAIL overflow_set got=ovf %b level %0d required=ovf 1 level 4",
                     overflow, level);
        end
        // Partial sixth frame; its last byte lands in the load (pop) cycle.
        send_byte(8'h61);
        send_byte(8'h62);
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_load !== 1'b1) begin
            failures++;
            $display("FAIL overflow_pop got=load %b required=1", out_load);
        end
        exp_q.push_back(24'h616263);
        in_valid  = 1'b1;
        in_data   = 8'h63;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (level !== 3'd4) begin
            failures++;
            $display("FAIL push_pop_level got=%0d required=4", level);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) serve_one("overflow");
        checks++;
        if (level !== 3'd0 || exp_q.size() != 0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_drain got=level %0d pending %0d ovf %b required=0 0 1",
                     level, exp_q.size(), overflow);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        send_frame(24'h0A0B0C, 1'b1);
        send_byte(8'h01);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        checks++;
        if (level !== 3'd0 || overflow !== 1'b0 || out_data !== 24'd0 || out_load !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=level %0d ovf %b data %h load %b required=0 0 0 0",
                     level, overflow, out_data, out_load);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_load !== 1'b0) begin
            failures++;
            $display("FAIL reset_load got=%b required=0", out_load);
        end
        send_frame(24'h020304, 1'b1);
        checks++;
        if (out_load !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got=load %b ovf %b required=load 1 ovf 0",
                     out_load, overflow);
        end
        finish_ack();
    endtask

    task automatic test_timeout();
        int drops;
        int first;
        drops = 0;
        first = -1;
        out_ready = 1'b1;
        send_byte(8'h11);
        send_byte(8'h22);
        for (int k = 0; k <= int'(TMO) + 100; k++) begin
            if (drop === 1'b1) begin
                drops++;
                if (first < 0) first = k;
            end
            @(negedge clk);
        end
`ifdef FRAME_TIMEOUT_EN
        checks++;
        if (drops != 1 || first != int'(TMO)) begin
            failures++;
            $display("FAIL timeout_drop got=%0d pulses at %0d required=1 at %0d",
                     drops, first, TMO);
        end
        send_frame(24'h334455, 1'b1);
`else
        checks++;
        if (drops != 0) begin
            failures++;
            $display("FAIL no_timeout_drop got=%0d pulses required=0", drops);
        end
        exp_q.push_back(24'h112233);
        send_byte(8'h33);
`endif
        checks++;
        if (out_load !== 1'b1 || level !== 3'd1) begin
            failures++;
            $display("FAIL timeout_frame got=load %b level %0d required=load 1 level 1",
                     out_load, level);
        end
        finish_ack();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL timeout_pending got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_lsb_first();
        send_byte2(8'h12);
        send_byte2(8'h34);
        checks++;
        if (out_load2 !== 1'b1) begin
            failures++;
            $display("FAIL lsb_load got=%b required=1", out_load2);
        end
        @(negedge clk);
        checks++;
        if (out_data2 !== 16'h3412) begin
            failures++;
            $display("FAIL lsb_data got=%h required=3412", out_data2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_queueing();
        test_overflow();
        test_timeout();
        test_mid_reset();
        test_lsb_first();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_packer.md
# uart_frame_packer

Parametrised successor to the fixed 8-to-24 byte packer between the UART receiver and the PT2262 encoder. Assembles `BYTES` consecutive received bytes into one frame and queues up to `DEPTH` complete frames in an internal FIFO. Releases frames one at a time to the encoder with a load pulse, gated by the encoder's done/idle level. An optional inter-byte timeout resynchronises the framing after a lost or corrupted byte.

## Interface
- `BYTES`, 3: bytes per frame; must be ≥1.
- `DEPTH`, 4: FIFO depth in frames; must be a power of 2 and ≥2.
- `MSB_FIRST`, 1: 1 = first byte goes to the top byte of the frame; 0 = first byte goes to bits [7:0].
- `TIMEOUT`, 1000: inter-byte timeout in clk cycles; must be ≥2. Used only with `FRAME_TIMEOUT_EN`.
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  one-cycle strobe per received byte.
- `in_data`  in  8  received byte; sampled when `in_valid`=1.
- `out_ready`  in  1  encoder idle/done level.
- `out_data`  out  8*BYTES  frame presented to the encoder; registered.
- `out_load`  out  1  one-cycle load pulse to the encoder.
- `level`  out  $clog2(DEPTH+1)  number of frames held in the FIFO.
- `overflow`  out  1  sticky flag: a complete frame was lost because the FIFO was full.
- `drop`  out  1  one-cycle pulse: a partial frame was discarded by timeout.

## Operation
- **Reset values:**
  - `out_data`=0, `out_load`=0, `level`=0, `overflow`=0, `drop`=0.
  - Byte index = 0, FIFO empty, output FSM in IDLE.
- **Accumulator:**
  - Each `in_valid` stores `in_data` at the current byte index, then increments the index.
  - With `MSB_FIRST`=1, index k writes bits [8*(BYTES-k)-1 -: 8].
  - On the byte with index BYTES-1, the completed frame (including that byte) is pushed to the FIFO in the same cycle and the index returns to 0.
- **Push when full:**
  - If the FIFO is full and no pop occurs that cycle, the frame is discarded, `overflow` sets and the FIFO is unchanged.
  - If a pop occurs in the same cycle, the push is accepted.
- **Simultaneous push and pop:** both happen; `level` is unchanged.
- **Output FSM:**
  - IDLE → LOAD when the FIFO is non-empty and `out_ready`=1.
  - LOAD: `out_data` takes the FIFO head, `out_load`=1 for exactly this cycle, head is popped; → WAIT.
  - WAIT: remains until `out_ready` is sampled 0 (encoder has started), then → IDLE. If the encoder never drops `out_ready`, the FSM stalls in WAIT; the FIFO keeps filling.
- `out_data` holds its value between loads.
- **Reset mid-operation:** discards the partial frame, all queued frames and any in-flight handshake. `out_load` never pulses in the cycle after reset.

## Timing
- Last byte strobe at cycle t (FIFO empty, FSM in IDLE, `out_ready`=1) → `level`=1 at t+1, `out_load` pulse at t+1, `out_data` valid from t+2.
- `level` and `overflow` update one cycle after the causing event.
- Back-to-back frames are separated by at least LOAD + WAIT + IDLE, i.e. 3 cycles plus the encoder busy time.
- Frames leave the FIFO in arrival order; the pointers wrap modulo `DEPTH`.

## Configuration
- `FRAME_TIMEOUT_EN` defined:
  - A counter clears on every `in_valid`.
  - While the byte index is >0 and TIMEOUT cycles pass with no byte, the index resets to 0 and `drop` pulses.
  - A byte arriving in the expiry cycle wins and counts as a continuation; no drop occurs.
- Not defined:
  - No counter is built and `drop` is tied 0.
  - A partial frame waits indefinitely.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE, LOAD, WAIT);
  - `BYTE_W`=8;
  - default values for `BYTES`, `DEPTH` and `TIMEOUT`.
- A single sub-module, `frame_fifo`: synchronous FIFO, width 8*BYTES, depth DEPTH, with push/pop/full/empty/level.
- The accumulator, timeout counter and output FSM stay in `uart_frame_packer`.

## Test plan
- **Basic frame:** bytes 0xA1, 0xB2, 0xC3 with `out_ready`=1, `MSB_FIRST`=1 → one `out_load` pulse, `out_data`=0xA1B2C3, `level` returns to 0.
- **Queueing:** hold `out_ready`=0 and send 4 frames → `level`=4, no `out_load`. Raise `out_ready` and toggle it low per load → 4 loads in arrival order.
- **Overflow:** with `level`=4 and `out_ready`=0, send a 5th frame → `overflow`=1, `level` stays 4, queued data intact. A later pop plus push in the same cycle keeps `level` unchanged.
- **Timeout (`FRAME_TIMEOUT_EN`, TIMEOUT=1000):**
  - Send 0x11, 0x22, idle 1000 cycles → `drop` pulse.
  - Then send 0x33, 0x44, 0x55 → `out_data`=0x334455.
- **Mid-frame reset:** send 0x01, pulse `reset`, then send 0x02, 0x03, 0x04 → `out_data`=0x020304, `overflow`=0.
- **`MSB_FIRST`=0, `BYTES`=2:** send 0x12, 0x34 → `out_data`=0x3412.
